pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response and the decode handoff.
interface pc_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            out_valid;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic            out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_gnt, imem_rvalid, imem_rdata, out_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch: IDLE issues, WAIT collects the response,
// HOLD presents it to decode. Branch/jump/trap redirects may arrive in any state.
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_if.master      bus,
  input  logic            br_valid,
  input  logic [1:0]      br_type,
  input  logic            equal,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            link_valid,
  output logic [XLEN-1:0] link_pc,
  output logic            misalign_err
);

  localparam logic [1:0] BR_BEQ  = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_JALR = 2'b11;
  localparam logic [XLEN-1:0] CLR_BIT0 = ~{{(XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            kill_reg, kill_next;
  logic [31:0]     out_instr_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic            link_valid_reg;
  logic [XLEN-1:0] link_pc_reg;
  logic            misalign_reg;
  logic            capture;

  logic [XLEN-1:0] jump_sum, jalr_sum, br_target, redirect_target;
  logic            is_jump, taken, br_aligned, redirect, br_misaligned, link_accept;

  always_comb begin
    jump_sum        = br_pc + imm;
    jalr_sum        = rs1_val + imm;
    is_jump         = br_type[1];
    taken           = br_valid && (is_jump ||
                                   (br_type == BR_BEQ && equal) ||
                                   (br_type == BR_BNE && !equal));
    br_target       = (br_type == BR_JALR) ? (jalr_sum & CLR_BIT0) : jump_sum;
    br_aligned      = (br_target[1:0] == 2'b00);
    // Traps always win and are never checked for alignment.
    redirect        = trap_valid || (taken && br_aligned);
    redirect_target = trap_valid ? trap_vec : br_target;
    br_misaligned   = !trap_valid && taken && !br_aligned;
    link_accept     = !trap_valid && taken && is_jump && br_aligned;
  end

  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    pc_next    = pc_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.imem_gnt) begin
          state_next = WAIT;
          kill_next  = redirect;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          // A killed or concurrently-redirected response is dropped and kill retires.
          kill_next = 1'b0;
          if (kill_reg || redirect) begin
            state_next = IDLE;
          end else begin
            state_next = HOLD;
            capture    = 1'b1;
          end
        end else if (redirect) begin
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || bus.out_ready) state_next = IDLE;
        if (bus.out_ready)             pc_next    = pc_reg + XLEN'(4);
      end
      default: state_next = IDLE;
    endcase
    if (redirect) pc_next = redirect_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      kill_reg       <= 1'b0;
      out_instr_reg  <= '0;
      out_pc_reg     <= '0;
      link_valid_reg <= 1'b0;
      link_pc_reg    <= '0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      kill_reg       <= kill_next;
      link_valid_reg <= link_accept;
      misalign_reg   <= br_misaligned;
      if (capture) begin
        out_instr_reg <= bus.imem_rdata;
        out_pc_reg    <= pc_reg;
      end
      if (link_accept) link_pc_reg <= br_pc + XLEN'(4);
    end
  end

  assign bus.imem_req  = (state_reg == IDLE) && !rst;
  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = (state_reg == HOLD) && !rst;
  assign bus.out_instr = out_instr_reg;
  assign bus.out_pc    = out_pc_reg;
  assign link_valid    = link_valid_reg;
  assign link_pc       = link_pc_reg;
  assign misalign_err  = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed table of per-cycle vectors for pc_fetch_unit plus reset sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [1:0]  br_type;
  logic        equal;
  logic [31:0] br_pc, imm, rs1_val, trap_vec;
  logic        trap_valid;
  logic        link_valid;
  logic [31:0] link_pc;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  pc_fetch_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .br_valid     (br_valid),
    .br_type      (br_type),
    .equal        (equal),
    .br_pc        (br_pc),
    .imm          (imm),
    .rs1_val      (rs1_val),
    .trap_valid   (trap_valid),
    .trap_vec     (trap_vec),
    .link_valid   (link_valid),
    .link_pc      (link_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy, brv;
    logic [1:0]  brt;
    logic        eq;
    logic [31:0] brpc, imm, rs1;
    logic        trv;
    logic [31:0] trvec;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] oi, opc;
    logic        lv;
    logic [31:0] lpc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic gnt, input logic rv, input logic [31:0] rdata, input logic rdy,
    input logic brv, input logic [1:0] brt, input logic eq,
    input logic [31:0] brpc, input logic [31:0] im, input logic [31:0] rs1,
    input logic trv, input logic [31:0] trvec,
    input logic req, input logic [31:0] addr, input logic ov,
    input logic [31:0] oi, input logic [31:0] opc,
    input logic lv, input logic [31:0] lpc, input logic mis);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.brv = brv; v.brt = brt;
    v.eq = eq; v.brpc = brpc; v.imm = im; v.rs1 = rs1; v.trv = trv; v.trvec = trvec;
    v.req = req; v.addr = addr; v.ov = ov; v.oi = oi; v.opc = opc;
    v.lv = lv; v.lpc = lpc; v.mis = mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.out_ready = 0;
    br_valid = 0; br_type = 0; equal = 0; br_pc = 0; imm = 0; rs1_val = 0;
    trap_valid = 0; trap_vec = 0;
  endtask

  task automatic check_outputs(input string tag, input logic req, input logic [31:0] addr,
                               input logic ov, input logic [31:0] oi, input logic [31:0] opc,
                               input logic lv, input logic [31:0] lpc, input logic mis);
    check({tag, ".imem_req"},     32'(bus.imem_req),  32'(req));
    check({tag, ".imem_addr"},    bus.imem_addr,      addr);
    check({tag, ".out_valid"},    32'(bus.out_valid), 32'(ov));
    check({tag, ".out_instr"},    bus.out_instr,      oi);
    check({tag, ".out_pc"},       bus.out_pc,         opc);
    check({tag, ".link_valid"},   32'(link_valid),    32'(lv));
    check({tag, ".link_pc"},      link_pc,            lpc);
    check({tag, ".misalign_err"}, 32'(misalign_err),  32'(mis));
  endtask

  initial begin
    //            gnt rv rdata        rdy brv brt   eq brpc         imm          rs1       trv trvec     req addr         ov oi           opc          lv lpc      mis
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h0,       0, 32'h0,       32'h0,       0, 32'h0,   0));
    vecs.push_back(mk(0, 1, 32'h13,       0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h0,       1, 32'h13,      32'h0,       0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'h4,       0, 32'h13,      32'h0,       0, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h4,       0, 32'h13,      32'h0,       0, 32'h0,   0));
    vecs.push_back(mk(0, 1, 32'hAAAA0001, 0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h4,       1, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    // HOLD with decode stalled; stray responses must not disturb the held instruction.
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 1, 32'hDEAD, 0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h4,       1, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'h8,       0, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h8,       0, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 2'd0, 1, 32'h100,      32'hFFFFFFF0, 32'h0,   0, 32'h0,   0, 32'hF0,      0, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    vecs.push_back(mk(0, 1, 32'hBAD,      0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'hF0,      0, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'hF0,      0, 32'hAAAA0001, 32'h4,      0, 32'h0,   0));
    vecs.push_back(mk(0, 1, 32'h1111,     0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'hF0,      1, 32'h1111,    32'hF0,      0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'hF4,      0, 32'h1111,    32'hF0,      0, 32'h0,   0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 2'd3, 0, 32'h200,      32'h4,       32'h2001, 0, 32'h0,   1, 32'h2004,    0, 32'h1111,    32'hF0,      1, 32'h204, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'h2004,    0, 32'h1111,    32'hF0,      0, 32'h204, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 2'd1, 1, 32'h300,      32'h40,      32'h0,    0, 32'h0,   1, 32'h2004,    0, 32'h1111,    32'hF0,      0, 32'h204, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 2'd2, 0, 32'h500,      32'h10,      32'h0,    1, 32'h80,  0, 32'h80,      0, 32'h1111,    32'hF0,      0, 32'h204, 0));
    vecs.push_back(mk(0, 1, 32'hBAD,      0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'h80,      0, 32'h1111,    32'hF0,      0, 32'h204, 0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h80,      0, 32'h1111,    32'hF0,      0, 32'h204, 0));
    vecs.push_back(mk(0, 1, 32'h2222,     0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h80,      1, 32'h2222,    32'h80,      0, 32'h204, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 2'd2, 0, 32'h80,       32'h100,     32'h0,    0, 32'h0,   1, 32'h180,     0, 32'h2222,    32'h80,      1, 32'h84,  0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'h180,     0, 32'h2222,    32'h80,      0, 32'h84,  0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 2'd2, 0, 32'h180,      32'h2,       32'h0,    0, 32'h0,   1, 32'h180,     0, 32'h2222,    32'h80,      0, 32'h84,  1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h180,     0, 32'h2222,    32'h80,      0, 32'h84,  0));
    vecs.push_back(mk(0, 1, 32'h3333,     0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h180,     1, 32'h3333,    32'h180,     0, 32'h84,  0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   1, 32'h184,     0, 32'h3333,    32'h180,     0, 32'h84,  0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h184,     0, 32'h3333,    32'h180,     0, 32'h84,  0));
    vecs.push_back(mk(0, 1, 32'hBAD,      0, 1, 2'd1, 0, 32'h184,      32'h1C,      32'h0,    0, 32'h0,   1, 32'h1A0,     0, 32'h3333,    32'h180,     0, 32'h84,  0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h1A0,     0, 32'h3333,    32'h180,     0, 32'h84,  0));
    vecs.push_back(mk(0, 1, 32'h4444,     0, 0, 2'd0, 0, 32'h0,        32'h0,       32'h0,    0, 32'h0,   0, 32'h1A0,     1, 32'h4444,    32'h1A0,     0, 32'h84,  0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 2'd2, 0, 32'hFFFFFFFC, 32'h8,       32'h0,    0, 32'h0,   1, 32'h4,       0, 32'h4444,    32'h1A0,     1, 32'h0,   0));

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    rst = 1'b0;
    #1;
    check("release.imem_req", 32'(bus.imem_req), 32'd1);
    check("release.imem_addr", bus.imem_addr, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.imem_gnt = vecs[i].gnt; bus.imem_rvalid = vecs[i].rv; bus.imem_rdata = vecs[i].rdata;
      bus.out_ready = vecs[i].rdy; br_valid = vecs[i].brv; br_type = vecs[i].brt;
      equal = vecs[i].eq; br_pc = vecs[i].brpc; imm = vecs[i].imm; rs1_val = vecs[i].rs1;
      trap_valid = vecs[i].trv; trap_vec = vecs[i].trvec;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].ov,
                    vecs[i].oi, vecs[i].opc, vecs[i].lv, vecs[i].lpc, vecs[i].mis);
      $display("vec %0d: req=%0d addr=0x%08h out_valid=%0d out_pc=0x%08h link=%0d mis=%0d",
               i, bus.imem_req, bus.imem_addr, bus.out_valid, bus.out_pc, link_valid, misalign_err);
    end

    // Reset while a request is outstanding, with a response and a jump in the same cycle.
    @(negedge clk);
    clear_inputs();
    bus.imem_gnt = 1;
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    bus.imem_rvalid = 1; bus.imem_rdata = 32'h5555;
    br_valid = 1; br_type = 2'd2; br_pc = 32'h10; imm = 32'h20;
    @(posedge clk);
    #1;
    check_outputs("midrst", 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    $display("midrst: req=%0d addr=0x%08h out_valid=%0d", bus.imem_req, bus.imem_addr, bus.out_valid);
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    check("midrst_release.imem_req", 32'(bus.imem_req), 32'd1);
    check("midrst_release.imem_addr", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1;
    @(negedge clk);
    clear_inputs();
    bus.imem_rvalid = 1; bus.imem_rdata = 32'h6666;
    @(posedge clk);
    #1;
    check_outputs("postrst", 0, 32'h0, 1, 32'h6666, 32'h0, 0, 32'h0, 0);
    $display("postrst: out_valid=%0d out_instr=0x%08h out_pc=0x%08h", bus.out_valid, bus.out_instr, bus.out_pc);
    @(negedge clk);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
